// File: rtl/audio_sample_buffer.sv
// Audio sample FIFO: circular RAM with a first-word-fall-through output
// register and a prefill gate that re-primes after the buffer runs dry.
module audio_sample_buffer #(
    parameter int DWIDTH  = 24,
    parameter int DEPTH   = 1024,
    parameter int PREFILL = 512
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [DWIDTH-1:0]        din_data_i,
    input  logic                     din_valid_i,
    output logic                     din_ready_o,
    output logic [DWIDTH-1:0]        dout_data_o,
    output logic                     dout_valid_o,
    input  logic                     dout_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        PRIMING,
        STREAMING
    } state_t;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [LW-1:0]     ram_cnt;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_data_q;
    state_t            state_q, state_d;

    logic wr_en;
    logic rd_en;
    logic load;

    assign din_ready_o  = !reset_i && (level_q < LW'(DEPTH));
    assign wr_en        = din_valid_i && din_ready_o;
    assign rd_en        = out_valid_q && dout_ready_i;
    // level counts the output register too, so RAM holds the remainder
    assign ram_cnt      = level_q - LW'(out_valid_q);
    assign dout_valid_o = out_valid_q;
    assign dout_data_o  = out_data_q;
    assign level_o      = level_q;

    // Prefill gate: decide when the output register may pull from RAM
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        underflow_o = 1'b0;
        unique case (state_q)
            PRIMING: begin
                if (level_q >= LW'(PREFILL)) begin
                    state_d = STREAMING;
                end
            end
            STREAMING: begin
                if (level_q == '0) begin
                    underflow_o = !reset_i;
                    state_d     = PRIMING;
                end else begin
                    load = (ram_cnt != '0) && (!out_valid_q || dout_ready_i);
                end
            end
        endcase
    end

    // Next-state for pointers, occupancy and output-register flag
    always_comb begin
        wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (rd_en) begin
            out_valid_d = 1'b0;
        end
        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control registers; reset flushes everything by rewinding pointers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            state_q     <= PRIMING;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            state_q     <= state_d;
        end
    end

    // Sample RAM write port, left unreset so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_data_i;
        end
    end

    // Synchronous RAM read straight into the output register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_data_q <= '0;
        end else if (load) begin
            out_data_q <= mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer: scoreboarded ramp, backpressure,
// underflow, random handshake and mid-stream reset scenarios.
module tb_audio_sample_buffer;

    localparam int DW      = 24;
    localparam int DEPTH   = 1024;
    localparam int PREFILL = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] din_data = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] dout_data;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [10:0]   level;
    logic          underflow;

    audio_sample_buffer #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH),
        .PREFILL(PREFILL)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .din_data_i  (din_data),
        .din_valid_i (din_valid),
        .din_ready_o (din_ready),
        .dout_data_o (dout_data),
        .dout_valid_o(dout_valid),
        .dout_ready_i(dout_ready),
        .level_o     (level),
        .underflow_o (underflow)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] next_in = '0;
    logic [DW-1:0] first_data = '0;
    int            level_m = 0;
    int            cyc_n = 0;
    int            n_out = 0;
    int            n_uf = 0;
    int            first_acc = -1;
    int            first_out = -1;
    int            gaps = 0;
    int            valid_seen = 0;
    logic          track = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_stats();
        n_out      = 0;
        n_uf       = 0;
        first_acc  = -1;
        first_out  = -1;
        gaps       = 0;
        valid_seen = 0;
    endtask

    task automatic cyc(input logic rst, input logic vin, input logic rdy);
        @(negedge clk);
        reset      = rst;
        din_valid  = vin;
        din_data   = next_in;
        dout_ready = rdy;
        #1;
        cyc_n++;
        if (rst) begin
            sb.delete();
            level_m = 0;
        end else begin
            check("level", 32'(level), 32'(level_m));
            check("din_ready", 32'(din_ready), 32'(level_m < DEPTH));
            if (dout_valid) valid_seen++;
            if (track && first_out >= 0 && !dout_valid) gaps++;
            if (dout_valid && first_out < 0) begin
                first_out  = cyc_n;
                first_data = dout_data;
            end
            if (underflow) n_uf++;
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'(dout_data), 32'hFFFFFFFF);
                end else begin
                    check("data", 32'(dout_data), 32'(sb.pop_front()));
                end
                n_out++;
                level_m--;
            end
            if (din_valid && din_ready) begin
                if (first_acc < 0) first_acc = cyc_n;
                sb.push_back(din_data);
                next_in = next_in + 1'b1;
                level_m++;
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
        next_in = '0;
        reset_stats();
    endtask

    initial begin
        // reset state
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout_data", 32'(dout_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        do_reset(497);

        // continuous ramp, about ten pointer wraps
        track = 1'b1;
        for (int i = 0; i < 10000; i++) cyc(1'b0, 1'b1, 1'b1);
        track = 1'b0;
        check("ramp_started", 32'(first_out >= 0), 32'd1);
        check("ramp_latency", 32'(first_out - first_acc <= PREFILL + 3), 32'd1);
        check("ramp_gaps", 32'(gaps), 32'd0);
        check("ramp_level", 32'(level >= 11'd512 && level <= 11'd516), 32'd1);
        check("ramp_count", 32'(n_out + int'(level)), 32'd10000);
        check("ramp_first", 32'(first_data), 32'd0);

        // backpressure fill, then full with a simultaneous read
        do_reset(2);
        for (int i = 0; i < 1100; i++) cyc(1'b0, 1'b1, 1'b0);
        check("full_level", 32'(level), 32'd1024);
        check("full_din_ready", 32'(din_ready), 32'd0);
        check("full_accepted", 32'(next_in), 32'd1024);
        cyc(1'b0, 1'b1, 1'b1);
        check("full_rd_no_wr", 32'(din_ready), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        check("full_next_wr", 32'(din_ready), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        check("full_refill", 32'(level), 32'd1024);
        for (int i = 0; i < 1100; i++) cyc(1'b0, 1'b0, 1'b1);
        check("bp_drain_count", 32'(n_out), 32'd1025);
        check("bp_drain_empty", 32'(sb.size()), 32'd0);

        // underflow and re-priming
        do_reset(2);
        for (int i = 0; i < 600; i++) cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 700; i++) cyc(1'b0, 1'b0, 1'b1);
        check("uf_count_out", 32'(n_out), 32'd600);
        check("uf_pulses", 32'(n_uf), 32'd1);
        check("uf_level", 32'(level), 32'd0);
        valid_seen = 0;
        for (int i = 0; i < 511; i++) cyc(1'b0, 1'b1, 1'b1);
        check("uf_reprime_hold", 32'(valid_seen), 32'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1);
        check("uf_reprime_go", 32'(valid_seen > 0), 32'd1);

        // random handshakes
        do_reset(2);
        for (int i = 0; i < 6000; i++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 600; i++) cyc(1'b0, 1'b1, 1'b1);
        check("rand_outputs", 32'(n_out > 0), 32'd1);

        // mid-stream reset at level 300
        do_reset(2);
        for (int i = 0; i < 520; i++) cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 220; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("pre_rst_level", 32'(level), 32'd300);
        check("pre_rst_valid", 32'(dout_valid), 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        reset_stats();
        next_in = 24'hA00000;
        for (int i = 0; i < 600; i++) cyc(1'b0, 1'b1, 1'b1);
        check("mid_rst_started", 32'(first_out >= 0), 32'd1);
        check("mid_rst_first", 32'(first_data), 32'h00A00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
